frame_capture_sequencer: RTL



---
 rtl/frame_capture_sequencer_pkg.sv | 33 +++
 rtl/frame_capture_sequencer_if.sv | 34 +++
 rtl/frame_capture_sequencer_edge_det.sv | 24 ++
 rtl/frame_capture_sequencer.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/frame_capture_sequencer_pkg.sv
// Shared types, defaults and helpers for the single-frame capture/readout sequencer.
package frame_seq_pkg;

    localparam int WORDS_PER_FRAME_DEF = 9600;       // 640*480/32 packed words
    localparam int LOAD_CYCLES_DEF     = 4;
    localparam int RD_LATENCY_DEF      = 2;
    localparam int TIMEOUT_CYCLES_DEF  = 50_000_000;

    // Binary state codes; the LEDR view is the one-hot expansion below.
    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_LOAD       = 3'd1,
        ST_WAIT_FRAME = 3'd2,
        ST_CAPTURE    = 3'd3,
        ST_READY      = 3'd4,
        ST_FETCH      = 3'd5,
        ST_DONE       = 3'd6,
        ST_ERROR      = 3'd7
    } state_e;

    // Counter width able to hold the terminal word count itself.
    function automatic int cw_for(input int words);
        return $clog2(words + 1);
    endfunction

    // One-hot LEDR encoding; bits 9:8 are always zero.
    function automatic logic [9:0] state_led(input logic [2:0] st);
        logic [9:0] led;
        led = {2'b00, (8'd1 << st)};
        return led;
    endfunction

endpackage

// File: rtl/frame_capture_sequencer_if.sv
// HPS / camera / SDRAM-side signal bundle of the frame capture sequencer.
interface frame_capture_sequencer_if #(
    parameter int CW = 14
);
    logic          iStart;
    logic          iAbort;
    logic          iFVAL;
    logic          iWr_Word;
    logic          iNext;
    logic [31:0]   iFifo_Data;
    logic          oCapture_En;
    logic          oFifo_Load;
    logic          oFifo_Rd;
    logic [31:0]   oData;
    logic          oValid;
    logic [CW-1:0] oWord_Cnt;
    logic          oDone;
    logic          oError;
    logic [9:0]    oState;

    // Environment side: drives requests and FIFO data, observes status.
    modport master (
        output iStart, iAbort, iFVAL, iWr_Word, iNext, iFifo_Data,
        input  oCapture_En, oFifo_Load, oFifo_Rd, oData, oValid,
               oWord_Cnt, oDone, oError, oState
    );

    // Sequencer side.
    modport slave (
        input  iStart, iAbort, iFVAL, iWr_Word, iNext, iFifo_Data,
        output oCapture_En, oFifo_Load, oFifo_Rd, oData, oValid,
               oWord_Cnt, oDone, oError, oState
    );
endinterface

// File: rtl/frame_capture_sequencer_edge_det.sv
// Rising-edge detector with registered history. The first cycle after reset
// never reports an edge, so a level already high at reset exit is ignored.
module seq_edge_det (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_sig,
    output logic o_rise
);
    logic r_prev;
    logic r_armed;

    // Track the previous level and arm after the first post-reset cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_prev  <= 1'b0;
            r_armed <= 1'b0;
        end else begin
            r_prev  <= i_sig;
            r_armed <= 1'b1;
        end
    end

    assign o_rise = r_armed & i_sig & ~r_prev;
endmodule

// File: rtl/frame_capture_sequencer.sv
// Single-frame capture and readout controller: arms on an HPS start edge,
// captures one aligned camera frame into SDRAM, then serves it word by word.
module frame_capture_sequencer
    import frame_seq_pkg::*;
#(
    parameter int WORDS_PER_FRAME = WORDS_PER_FRAME_DEF,
    parameter int LOAD_CYCLES     = LOAD_CYCLES_DEF,
    parameter int RD_LATENCY      = RD_LATENCY_DEF,
    parameter int TIMEOUT_CYCLES  = TIMEOUT_CYCLES_DEF,
    parameter int CW              = cw_for(WORDS_PER_FRAME)
) (
    input  logic                iCLK,
    input  logic                iRST_N,
    frame_capture_sequencer_if.slave bus
);
    localparam logic [2:0]    S_IDLE       = ST_IDLE;
    localparam logic [2:0]    S_LOAD       = ST_LOAD;
    localparam logic [2:0]    S_WAIT_FRAME = ST_WAIT_FRAME;
    localparam logic [2:0]    S_CAPTURE    = ST_CAPTURE;
    localparam logic [2:0]    S_READY      = ST_READY;
    localparam logic [2:0]    S_FETCH      = ST_FETCH;
    localparam logic [2:0]    S_DONE       = ST_DONE;
    localparam logic [2:0]    S_ERROR      = ST_ERROR;
    localparam logic [CW-1:0] W_TERM       = CW'(WORDS_PER_FRAME);
    localparam logic [CW-1:0] CNT_ONE      = CW'(1);
    localparam logic [31:0]   T_LOAD_LAST  = 32'(LOAD_CYCLES - 1);
    localparam logic [31:0]   T_RD_LAST    = 32'(RD_LATENCY - 1);
    localparam logic [31:0]   T_TIMEOUT    = 32'(TIMEOUT_CYCLES);

    logic w_start_rise, w_fval_rise;
    logic [2:0]    r_state, w_state;
    logic [31:0]   r_tmo,   w_tmo;     // load length, frame timeout or read latency
    logic [CW-1:0] r_cnt,   w_cnt, w_cnt_inc;
    logic [31:0]   r_data,  w_data;
    logic          r_cap,   w_cap;
    logic          r_load,  w_load;
    logic          r_rd,    w_rd;
    logic          r_valid, w_valid;
    logic          r_done,  w_done;
    logic          r_err,   w_err;
    logic [9:0]    r_led;

    seq_edge_det u_start_edge (.i_clk(iCLK), .i_rst_n(iRST_N), .i_sig(bus.iStart), .o_rise(w_start_rise));
    seq_edge_det u_fval_edge  (.i_clk(iCLK), .i_rst_n(iRST_N), .i_sig(bus.iFVAL),  .o_rise(w_fval_rise));

    // Next-state and next-output logic; abort overrides every state.
    always_comb begin
        w_cnt_inc = (bus.iWr_Word && (r_cnt != W_TERM)) ? (r_cnt + CNT_ONE) : r_cnt;
        w_state   = r_state;
        w_tmo     = r_tmo + 32'd1;
        w_cnt     = r_cnt;
        w_cap     = r_cap;
        w_load    = 1'b0;
        w_rd      = 1'b0;
        w_data    = r_data;
        w_valid   = r_valid;
        w_done    = r_done;
        w_err     = r_err;
        if (bus.iAbort) begin
            w_state = S_IDLE;
            w_tmo   = 32'd0;
            w_cnt   = '0;
            w_cap   = 1'b0;
            w_valid = 1'b0;
            w_done  = 1'b0;
            w_err   = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start_rise) begin
                        w_state = S_LOAD;
                        w_tmo   = 32'd0;
                        w_cnt   = '0;
                        w_load  = 1'b1;
                        w_valid = 1'b0;
                        w_done  = 1'b0;
                        w_err   = 1'b0;
                    end else begin
                        w_tmo = 32'd0;
                    end
                end
                S_LOAD: begin
                    if (r_tmo == T_LOAD_LAST) begin
                        w_state = S_WAIT_FRAME;
                        w_tmo   = 32'd0;
                    end else begin
                        w_load = 1'b1;
                    end
                end
                S_WAIT_FRAME: begin
                    if (w_fval_rise) begin
                        w_state = S_CAPTURE;
                        w_cap   = 1'b1;
                        w_tmo   = 32'd0;
                    end else if (w_tmo == T_TIMEOUT) begin
                        w_state = S_ERROR;
                        w_err   = 1'b1;
                    end else begin
                        w_state = S_WAIT_FRAME;
                    end
                end
                S_CAPTURE: begin
                    // The pulse arriving in the same cycle still counts toward the frame.
                    if (w_cnt_inc == W_TERM) begin
                        w_state = S_READY;
                        w_cap   = 1'b0;
                        w_cnt   = '0;
                    end else if (!bus.iFVAL) begin
                        w_state = S_ERROR;
                        w_cap   = 1'b0;
                        w_err   = 1'b1;
                        w_cnt   = w_cnt_inc;
                    end else begin
                        w_cnt = w_cnt_inc;
                    end
                end
                S_READY: begin
                    if (bus.iNext) begin
                        w_state = S_FETCH;
                        w_rd    = 1'b1;
                        w_valid = 1'b0;
                        w_tmo   = 32'd0;
                    end else begin
                        w_state = S_READY;
                    end
                end
                S_FETCH: begin
                    if (r_tmo == T_RD_LAST) begin
                        w_data  = bus.iFifo_Data;
                        w_valid = 1'b1;
                        w_cnt   = r_cnt + CNT_ONE;
                        if ((r_cnt + CNT_ONE) == W_TERM) begin
                            w_state = S_DONE;
                            w_done  = 1'b1;
                        end else begin
                            w_state = S_READY;
                        end
                    end else begin
                        w_state = S_FETCH;
                    end
                end
                S_DONE: begin
                    if (!bus.iStart) begin
                        w_state = S_IDLE;
                        w_done  = 1'b0;
                        w_cnt   = '0;
                    end else begin
                        w_state = S_DONE;
                    end
                end
                S_ERROR: begin
                    w_cap = 1'b0;
                    if (!bus.iStart) begin
                        w_state = S_IDLE;
                        w_cnt   = '0;
                    end else begin
                        w_state = S_ERROR;
                    end
                end
                default: begin
                    w_state = S_IDLE;
                    w_cap   = 1'b0;
                end
            endcase
        end
    end

    // State, counters and all outputs are registered together.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_state <= S_IDLE;
            r_tmo   <= 32'd0;
            r_cnt   <= '0;
            r_data  <= 32'd0;
            r_cap   <= 1'b0;
            r_load  <= 1'b0;
            r_rd    <= 1'b0;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_led   <= 10'b0000000001;
        end else begin
            r_state <= w_state;
            r_tmo   <= w_tmo;
            r_cnt   <= w_cnt;
            r_data  <= w_data;
            r_cap   <= w_cap;
            r_load  <= w_load;
            r_rd    <= w_rd;
            r_valid <= w_valid;
            r_done  <= w_done;
            r_err   <= w_err;
            r_led   <= state_led(w_state);
        end
    end

    assign bus.oCapture_En = r_cap;
    assign bus.oFifo_Load  = r_load;
    assign bus.oFifo_Rd    = r_rd;
    assign bus.oData       = r_data;
    assign bus.oValid      = r_valid;
    assign bus.oWord_Cnt   = r_cnt;
    assign bus.oDone       = r_done;
    assign bus.oError      = r_err;
    assign bus.oState      = r_led;
endmodule
